// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync marker, LSB-first payload, then an idle guard gap
// on a single registered line feeding the marker detector.
module seq_frame_tx #(
    parameter int unsigned       DATA_W  = 16,
    parameter int unsigned       SYNC_W  = 5,
    parameter logic [SYNC_W-1:0] SYNC    = 5'b11001,
    parameter int unsigned       GAP_LEN = 2
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              seq,
    output logic              busy,
    output logic              done
);

    localparam int unsigned MAX_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int unsigned MAX_LEN = (MAX_SD > GAP_LEN) ? MAX_SD : GAP_LEN;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] SYNC_END  = CNT_W'(SYNC_W);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam bit               HAS_GAP   = (GAP_LEN > 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_GAP
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              seq_q, seq_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            seq_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            seq_q   <= seq_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state; in SYNC the counter is the index of the next marker bit to drive,
    // in DATA/GAP it is the index of the bit or gap cycle currently on the line.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SYNC;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_SYNC: begin
                if (cnt_q == SYNC_END) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == DATA_LAST) begin
                    state_d = HAS_GAP ? S_GAP : S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered line, status and shift-register updates
    always_comb begin
        seq_d  = 1'b0;
        busy_d = busy_q;
        done_d = 1'b0;
        sh_d   = sh_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sh_d   = data;
                    busy_d = 1'b1;
                    seq_d  = SYNC[0];
                end
            end
            S_SYNC: begin
                if (cnt_q == SYNC_END) begin
                    seq_d  = sh_q[0];
                    sh_d   = sh_q >> 1;
                    done_d = (DATA_LAST == '0);
                end else begin
                    seq_d = |(SYNC & (SYNC_W'(1) << cnt_q));
                end
            end
            S_DATA: begin
                if (cnt_q == DATA_LAST) begin
                    busy_d = HAS_GAP;
                end else begin
                    seq_d  = sh_q[0];
                    sh_d   = sh_q >> 1;
                    done_d = ((cnt_q + CNT_W'(1)) == DATA_LAST);
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    busy_d = 1'b0;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign seq  = seq_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Scoreboard bench for seq_frame_tx: a frame-level model queues the expected line
// contents on each accepted start; a negedge monitor pops and compares while busy.
module tb_seq_frame_tx;

    localparam int unsigned DW    = 16;
    localparam int unsigned SW    = 5;
    localparam int unsigned GAP   = 2;
    localparam int unsigned FRAME = SW + DW + GAP;
    localparam logic [4:0]  SYNC_PAT = 5'b11001;

    logic          clk = 1'b0;
    logic          res;
    logic          start, start2;
    logic [DW-1:0] data, data2;
    logic          seq, busy, done;
    logic          seq2, busy2, done2;

    typedef struct packed {
        logic s;
        logic d;
    } exp_t;

    exp_t sb_q[$];
    int   m_left;

    int m_checks = 0, m_errs = 0;
    int s_checks = 0, s_errs = 0;

    int          run_len = 0;
    int          dut_frames = 0;
    int          done_cnt = 0;
    int          det_cnt = 0;
    int          det_at_sync = 0;
    logic        prev_busy = 1'b0;
    logic [4:0]  hist = '0;
    logic [22:0] cap = '0;
    int          cap_n = 0;

    seq_frame_tx #(.DATA_W(DW), .SYNC_W(SW), .SYNC(5'b11001), .GAP_LEN(GAP)) dut (
        .clk(clk), .res(res), .start(start), .data(data),
        .seq(seq), .busy(busy), .done(done)
    );

    seq_frame_tx #(.DATA_W(DW), .SYNC_W(SW), .SYNC(5'b11001), .GAP_LEN(0)) dut0 (
        .clk(clk), .res(res), .start(start2), .data(data2),
        .seq(seq2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    // Bit i of a frame carrying payload d, straight from the frame layout
    function automatic logic fbit(input logic [DW-1:0] d, input int i);
        if (i < int'(SW))           return SYNC_PAT[i];
        else if (i < int'(SW + DW)) return d[i - int'(SW)];
        else                        return 1'b0;
    endfunction

    task automatic chk_m(input string name, input logic [31:0] act, input logic [31:0] exp);
        m_checks++;
        if (act !== exp) begin
            m_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_s(input string name, input logic [31:0] act, input logic [31:0] exp);
        s_checks++;
        if (act !== exp) begin
            s_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is accepted whenever the line is free at an edge
    always @(posedge clk or negedge res) begin
        if (!res) begin
            m_left = 0;
            sb_q.delete();
        end else if (m_left == 0) begin
            if (start) begin
                for (int i = 0; i < int'(FRAME); i++)
                    sb_q.push_back('{s: fbit(data, i), d: (i == int'(SW + DW) - 1)});
                m_left = FRAME;
            end
        end else begin
            m_left = m_left - 1;
        end
    end

    // Monitor: compare line state mid-cycle against the queued expectations
    always @(negedge clk) begin
        exp_t e;
        if (!res) begin
            chk_s("reset_line", {29'b0, seq, busy, done}, 32'h0);
            run_len   = 0;
            hist      = '0;
            prev_busy = 1'b0;
        end else begin
            chk_s("busy", 32'(busy), 32'(m_left > 0));
            if (busy) begin
                if (!prev_busy) dut_frames++;
                run_len++;
                if (sb_q.size() == 0) begin
                    chk_s("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk_s("seq", 32'(seq), 32'(e.s));
                    chk_s("done", 32'(done), 32'(e.d));
                end
                if (cap_n < 23) begin
                    cap[cap_n] = seq;
                    cap_n++;
                end
            end else begin
                chk_s("idle_line", {30'b0, seq, done}, 32'h0);
                if (run_len > 0) chk_s("busy_len", 32'(run_len), 32'(FRAME));
                run_len = 0;
            end
            if (done) done_cnt++;
            prev_busy = busy;
            hist = {hist[3:0], seq};
            if (hist == 5'b10011) begin
                det_cnt++;
                if (run_len == int'(SW)) det_at_sync++;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (m_left != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (m_left != 0) chk_m("idle_timeout", 32'(m_left), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic send(input logic [DW-1:0] d);
        data  = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int d0, f0, dc0;
        int n;
        res    = 1'b0;
        start  = 1'b1;
        data   = 16'hA5C3;
        start2 = 1'b0;
        data2  = 16'h5A3C;

        // Reset held with start high, released at 17 ns
        #3  chk_m("rst_3ns",  {29'b0, seq, busy, done}, 32'h0);
        #5  chk_m("rst_8ns",  {29'b0, seq, busy, done}, 32'h0);
        #5  chk_m("rst_13ns", {29'b0, seq, busy, done}, 32'h0);
        #4  res = 1'b1;
        @(negedge clk);
        chk_m("not_yet_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk_m("first_sync_bit", {30'b0, seq, busy}, 32'h3);
        wait_idle();
        chk_m("frame_a5c3", 32'(cap), 32'({2'b00, 16'hA5C3, 5'b11001}));
        chk_m("done_once", 32'(done_cnt), 32'd1);

        // Loopback through a 10011 detector
        d0 = det_cnt;
        f0 = det_at_sync;
        send(16'h0000);
        wait_idle();
        send(16'hA5C3);
        wait_idle();
        chk_m("det_count", 32'(det_cnt - d0), 32'd2);
        chk_m("det_after_sync", 32'(det_at_sync - f0), 32'd2);

        // Start while busy is ignored and payload stays latched
        f0 = dut_frames;
        send(16'h0000);
        repeat (11) @(negedge clk);
        send(16'hFFFF);
        wait_idle();
        repeat (5) @(negedge clk);
        chk_m("no_second_frame", 32'(dut_frames - f0), 32'd1);

        // Reset during payload bit 10
        dc0 = done_cnt;
        send(16'hFFFF);
        repeat (15) @(negedge clk);
        chk_m("pre_abort", {30'b0, seq, busy}, 32'h3);
        #1 res = 1'b0;
        #1 chk_m("abort_line", {29'b0, seq, busy, done}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #2 res = 1'b1;
        @(negedge clk);
        chk_m("abort_no_done", 32'(done_cnt), 32'(dc0));
        send(16'h1234);
        wait_idle();
        chk_m("post_abort_done", 32'(done_cnt), 32'(dc0 + 1));

        // Randomized start pulses, including long holds for back-to-back frames
        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(0, 30);
            for (int c = 0; c < n; c++) begin
                data = 16'($urandom);
                @(negedge clk);
            end
            start = 1'b1;
            n = $urandom_range(1, 50);
            for (int c = 0; c < n; c++) begin
                data = 16'($urandom);
                @(negedge clk);
            end
            start = 1'b0;
        end
        wait_idle();
        chk_m("sb_drained", 32'(sb_q.size()), 32'd0);

        // No-gap instance with start held: 21-bit frames, one idle bit between
        start2 = 1'b1;
        n = 0;
        @(negedge clk);
        while (!busy2 && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk_m("gap0_started", 32'(busy2), 32'd1);
        for (int t = 0; t < 66; t++) begin
            int p;
            p = t % 22;
            chk_m("gap0_seq",  32'(seq2),  32'(fbit(data2, p)));
            chk_m("gap0_busy", 32'(busy2), 32'(p < 21));
            chk_m("gap0_done", 32'(done2), 32'(p == 20));
            @(negedge clk);
        end
        start2 = 1'b0;
        repeat (30) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 m_checks + s_checks, m_errs + s_errs);
        $finish;
    end

endmodule
